dds_spi_sequencer: RTL and testbench

DDS_SPI_SEQUENCER -- requirements
Module: dds_spi_sequencer

---
 rtl/dds_spi_sequencer.sv | 144 ++++++++++++++
 tb/tb_dds_spi_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_spi_sequencer.sv
// Serial-port frame sequencer for a DDS: optional IO_RESET pulse, MSB-first
// SPI shift under CSB, settle gap, IO_UPDATE pulse, then digital-ramp direction.
module dds_spi_sequencer #(
    parameter int SCLK_HALF = 3,
    parameter int MAX_BYTES = 29,
    parameter int RST_CYC   = 50,
    parameter int UPD_CYC   = 50,
    parameter int GAP_CYC   = 480,
    localparam int NB       = MAX_BYTES * 8,
    localparam int LW       = $clog2(MAX_BYTES + 1)
) (
    input  logic          fifty_MHz_intclk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [NB-1:0] frame_data,
    input  logic [LW-1:0] frame_len,
    input  logic          do_io_reset,
    input  logic          ramp_dir,
    output logic          SDIO,
    output logic          SCLK,
    output logic          CSB,
    output logic          IO_RESET,
    output logic          IO_UPDATE,
    output logic          DR_CTL,
    output logic          DR_HOLD,
    output logic          OSK,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int CMAX = (GAP_CYC > RST_CYC) ? ((GAP_CYC > UPD_CYC) ? GAP_CYC : UPD_CYC)
                                               : ((RST_CYC > UPD_CYC) ? RST_CYC : UPD_CYC);
    localparam int CW   = $clog2(CMAX + 1);
    localparam int HW   = $clog2(SCLK_HALF + 1);
    localparam int BW   = $clog2(NB + 1);

    typedef enum logic [2:0] {IDLE, RSTP, GAP1, SHIFT, GAP2, UPD, DONE} state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hcnt;
    logic          ph;
    logic [BW-1:0] bcnt;
    logic [NB-1:0] sreg;
    logic [LW-1:0] len_l;
    logic          ramp_l;
    logic [BW-1:0] nbits_m1;
    logic          len_ok, accept, half_last, bit_last, timed;

    assign DR_HOLD   = 1'b0;
    assign OSK       = 1'b0;
    assign len_ok    = (frame_len != '0) && (frame_len <= LW'(MAX_BYTES));
    assign accept    = start && len_ok;
    assign nbits_m1  = BW'({len_l, 3'b000}) - BW'(1);
    assign half_last = (hcnt == HW'(SCLK_HALF - 1));
    assign bit_last  = (bcnt == nbits_m1);
    assign timed     = (state == RSTP) || (state == GAP1) || (state == GAP2) || (state == UPD);

    always_ff @(posedge fifty_MHz_intclk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    end

    // Pins decode straight from state so abort and reset reach them without an extra stage.
    always_comb begin
        nxt       = state;
        CSB       = 1'b1;
        SCLK      = 1'b0;
        SDIO      = 1'b0;
        IO_RESET  = 1'b0;
        IO_UPDATE = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) nxt = do_io_reset ? RSTP : SHIFT;
            end
            RSTP: begin
                IO_RESET = 1'b1;
                if (cnt == CW'(RST_CYC - 1)) nxt = GAP1;
            end
            GAP1: if (cnt == CW'(GAP_CYC - 1)) nxt = SHIFT;
            SHIFT: begin
                CSB  = 1'b0;
                SCLK = ph;
                SDIO = sreg[NB-1];
                if (half_last && ph && bit_last) nxt = GAP2;
            end
            GAP2: if (cnt == CW'(GAP_CYC - 1)) nxt = UPD;
            UPD: begin
                IO_UPDATE = 1'b1;
                if (cnt == CW'(UPD_CYC - 1)) nxt = DONE;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
        if (state != IDLE && abort) nxt = IDLE;
    end

    always_ff @(posedge fifty_MHz_intclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            hcnt   <= '0;
            ph     <= 1'b0;
            bcnt   <= '0;
            sreg   <= '0;
            len_l  <= '0;
            ramp_l <= 1'b0;
            DR_CTL <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= ((state == IDLE) && start && !len_ok) || ((state != IDLE) && abort);
            cnt <= (timed && state == nxt) ? cnt + CW'(1) : '0;
            if (state == IDLE && accept) begin
                sreg   <= frame_data;
                len_l  <= frame_len;
                ramp_l <= ramp_dir;
                hcnt   <= '0;
                ph     <= 1'b0;
                bcnt   <= '0;
            end
            // SDIO advances only as the high phase ends, i.e. at the start of the next low phase.
            if (state == SHIFT) begin
                if (half_last) begin
                    hcnt <= '0;
                    ph   <= ~ph;
                    if (ph) begin
                        sreg <= {sreg[NB-2:0], 1'b0};
                        bcnt <= bcnt + BW'(1);
                    end
                end else begin
                    hcnt <= hcnt + HW'(1);
                end
            end
            if (state == UPD && nxt == DONE) DR_CTL <= ramp_l;
        end
    end
endmodule

// File: tb/tb_dds_spi_sequencer.sv
// Scoreboard bench: stimulus queues expected SDIO bits and frame-end events;
// a negedge monitor consumes them as SCLK edges and done/err pulses appear.
module tb_dds_spi_sequencer;
    localparam int H  = 2;
    localparam int MB = 29;
    localparam int NB = MB * 8;
    localparam int LW = 5;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic          do_io_reset = 1'b0, ramp_dir = 1'b0;
    logic [NB-1:0] frame_data = '0;
    logic [LW-1:0] frame_len = '0;
    logic          SDIO, SCLK, CSB, IO_RESET, IO_UPDATE, DR_CTL, DR_HOLD, OSK, busy, done, err;

    dds_spi_sequencer #(.SCLK_HALF(H), .MAX_BYTES(MB), .RST_CYC(50), .UPD_CYC(50), .GAP_CYC(480)) dut (
        .fifty_MHz_intclk(clk), .reset_n(rst_n), .start(start), .abort(abort),
        .frame_data(frame_data), .frame_len(frame_len), .do_io_reset(do_io_reset),
        .ramp_dir(ramp_dir), .SDIO(SDIO), .SCLK(SCLK), .CSB(CSB), .IO_RESET(IO_RESET),
        .IO_UPDATE(IO_UPDATE), .DR_CTL(DR_CTL), .DR_HOLD(DR_HOLD), .OSK(OSK),
        .busy(busy), .done(done), .err(err));

    always #5 clk = ~clk;

    typedef struct {
        bit is_err;
        int edges;
        int csb;
        int upd;
        bit chk_rst;
        int rst;
        int gap;
        bit dr;
    } ev_t;

    ev_t ev_q[$];
    bit  bit_q[$];
    int  n_tests = 0, n_fail = 0;
    bit  exp_dr = 1'b0;

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int m_edges = 0, m_csb = 0, m_upd = 0, m_rst = 0, m_gap = 0;
    bit m_rst_seen = 0, m_csb_seen = 0;
    logic p_sclk = 0, p_upd = 0, p_dr = 0;

    task automatic clr_frame();
        m_edges = 0; m_csb = 0; m_upd = 0; m_rst = 0; m_gap = 0;
        m_rst_seen = 0; m_csb_seen = 0;
    endtask

    initial begin
        bit  b;
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bit_q.delete();
                clr_frame();
                p_sclk = 0; p_upd = 0; p_dr = DR_CTL;
            end else begin
                if (SCLK && !p_sclk) begin
                    m_edges++;
                    if (bit_q.size() == 0) check("extra_sclk_edge", 1, 0);
                    else begin
                        b = bit_q.pop_front();
                        check("sdio_bit", int'(SDIO), int'(b));
                    end
                end
                if (!CSB) m_csb++;
                if (IO_UPDATE) m_upd++;
                if (IO_RESET) begin m_rst++; m_rst_seen = 1; end
                else if (m_rst_seen && !m_csb_seen && CSB) m_gap++;
                if (!CSB) m_csb_seen = 1;
                if (DR_CTL !== p_dr) check("dr_ctl_change_at_upd_fall", int'(p_upd && !IO_UPDATE), 1);
                if (done || err) begin
                    if (ev_q.size() == 0) check("unexpected_done_err", 1, 0);
                    else begin
                        e = ev_q.pop_front();
                        check("event_is_err", int'(err), int'(e.is_err));
                        check("sclk_edges", m_edges, e.edges);
                        check("csb_low_cycles", m_csb, e.csb);
                        check("io_update_cycles", m_upd, e.upd);
                        check("dr_ctl", int'(DR_CTL), int'(e.dr));
                        check("busy_at_end", int'(busy), 0);
                        check("csb_at_end", int'(CSB), 1);
                        if (e.chk_rst) begin
                            check("io_reset_cycles", m_rst, e.rst);
                            check("gap1_cycles", m_gap, e.gap);
                        end
                    end
                    clr_frame();
                end
                p_sclk = SCLK; p_upd = IO_UPDATE; p_dr = DR_CTL;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_frame(int len, logic [NB-1:0] d, bit ior, bit rd, bit with_evt);
        ev_t e;
        for (int i = 0; i < len * 8; i++) bit_q.push_back(d[NB-1-i]);
        if (with_evt) begin
            e.is_err = 0; e.edges = len * 8; e.csb = len * 8 * 2 * H; e.upd = 50;
            e.chk_rst = ior; e.rst = 50; e.gap = 480; e.dr = rd;
            ev_q.push_back(e);
            exp_dr = rd;
        end
    endtask

    task automatic push_err(int edges, int csb);
        ev_t e;
        e.is_err = 1; e.edges = edges; e.csb = csb; e.upd = 0;
        e.chk_rst = 0; e.rst = 0; e.gap = 0; e.dr = exp_dr;
        ev_q.push_back(e);
    endtask

    task automatic issue(int len, logic [NB-1:0] d, bit ior, bit rd, bit with_abort, bit ok);
        @(negedge clk);
        frame_data = d; frame_len = LW'(len); do_io_reset = ior; ramp_dir = rd;
        start = 1; abort = with_abort;
        @(negedge clk);
        start = 0; abort = 0;
        frame_data = ~d; frame_len = LW'(7); do_io_reset = ~ior; ramp_dir = ~rd;
        check("busy_after_start", int'(busy), int'(ok));
    endtask

    task automatic wait_drain(string name);
        int cyc = 0;
        while ((ev_q.size() != 0 || busy) && cyc < 6000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_completes_in_time"}, int'(cyc < 6000), 1);
        if (cyc >= 6000) ev_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_csb_low(string name);
        int cyc = 0;
        while (CSB && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_csb_falls"}, int'(cyc < 2000), 1);
    endtask

    function automatic logic [NB-1:0] pattern(int seed);
        logic [NB-1:0] d;
        for (int i = 0; i < MB; i++) d[i*8 +: 8] = 8'((i * 37 + seed * 11 + 5) & 255);
        return d;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic [NB-1:0] d;
        int edges, cyc, upd_seen;
        logic ps;

        #2;
        check("rst_csb", int'(CSB), 1);
        check("rst_pins_low", int'({SDIO, SCLK, IO_RESET, IO_UPDATE, DR_CTL, DR_HOLD, OSK}), 0);
        check("rst_status_low", int'({busy, done, err}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // 0xA5 single byte, no IO_RESET, ramp down
        d = pattern(1); d[NB-1 -: 8] = 8'hA5;
        push_frame(1, d, 0, 0, 1);
        issue(1, d, 0, 0, 0, 1);
        wait_drain("frame_a5");

        // IO_RESET preamble; start and abort together: start wins; ramp up
        d = pattern(2);
        push_frame(2, d, 1, 1, 1);
        issue(2, d, 1, 1, 1, 1);
        wait_drain("frame_ioreset");

        // second start mid-shift is ignored; ramp back down
        d = pattern(3);
        push_frame(4, d, 0, 0, 1);
        issue(4, d, 0, 0, 0, 1);
        wait_csb_low("midstart");
        repeat (20) @(negedge clk);
        frame_data = pattern(9); frame_len = LW'(2); ramp_dir = 1; start = 1;
        @(negedge clk);
        start = 0;
        wait_drain("frame_midstart");

        // full-length frame
        d = pattern(4);
        push_frame(MB, d, 0, 1, 1);
        issue(MB, d, 0, 1, 0, 1);
        wait_drain("frame_full");

        // illegal lengths
        push_err(0, 0);
        issue(0, pattern(5), 0, 0, 0, 0);
        wait_drain("reject_len0");
        push_err(0, 0);
        issue(30, pattern(6), 1, 0, 0, 0);
        wait_drain("reject_len30");

        // abort right after the 40th rising edge
        d = pattern(7);
        for (int i = 0; i < 40; i++) bit_q.push_back(d[NB-1-i]);
        push_err(40, 39 * 2 * H + H + 1);
        issue(8, d, 0, 0, 0, 1);
        edges = 0; ps = 0; cyc = 0;
        while (edges < 40 && cyc < 3000) begin
            @(negedge clk);
            if (SCLK && !ps) edges++;
            ps = SCLK;
            cyc++;
        end
        check("abort_edge_reached", edges, 40);
        abort = 1;
        @(negedge clk);
        abort = 0;
        check("abort_csb_next_clock", int'(CSB), 1);
        wait_drain("frame_abort");

        d = pattern(8);
        push_frame(2, d, 0, 0, 1);
        issue(2, d, 0, 0, 0, 1);
        wait_drain("frame_after_abort");

        // reset mid-shift: pins drop immediately, no IO_UPDATE afterwards
        d = pattern(10);
        push_frame(10, d, 0, 1, 0);
        issue(10, d, 0, 1, 0, 1);
        wait_csb_low("rstmid");
        repeat (60) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("rstmid_csb", int'(CSB), 1);
        check("rstmid_pins_low", int'({SDIO, SCLK, IO_RESET, IO_UPDATE, DR_CTL}), 0);
        check("rstmid_status_low", int'({busy, done, err}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        exp_dr = 0;
        upd_seen = 0;
        repeat (700) begin
            @(negedge clk);
            if (IO_UPDATE || busy) upd_seen++;
        end
        check("no_activity_after_reset", upd_seen, 0);
        check("bits_flushed_by_reset", bit_q.size(), 0);

        d = pattern(11);
        push_frame(3, d, 1, 1, 1);
        issue(3, d, 1, 1, 0, 1);
        wait_drain("frame_after_reset");

        check("bit_queue_empty", bit_q.size(), 0);
        check("event_queue_empty", ev_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
